// File: rtl/jelly_bean_dispenser_pkg.sv
// Shared types for the jelly bean dispenser and taster.
package jb_pkg;

    typedef enum logic [2:0] {
        NO_FLAVOR  = 3'd0,
        APPLE      = 3'd1,
        BLUEBERRY  = 3'd2,
        BUBBLE_GUM = 3'd3,
        CHOCOLATE  = 3'd4
    } flavor_e;

    typedef enum logic [1:0] {
        RED   = 2'd0,
        GREEN = 2'd1,
        BLUE  = 2'd2
    } color_e;

    typedef enum logic [1:0] {
        UNKNOWN = 2'd0,
        YUMMY   = 2'd1,
        YUCKY   = 2'd2
    } taste_e;

    typedef enum logic [1:0] {
        StIdle,
        StDrive,
        StWait,
        StReport
    } disp_state_e;

    // Flavor kept as raw bits so out-of-range codes 5..7 survive the FIFO intact.
    typedef struct packed {
        logic [2:0] flavor;
        logic [1:0] color;
        logic       sugar_free;
        logic       sour;
    } order_t;

    localparam int unsigned ORDER_W = $bits(order_t);

    // Idle bus encodes as all zeros, which is also the reset value.
    localparam order_t BEAN_IDLE = '{flavor: NO_FLAVOR, color: RED, sugar_free: 1'b0, sour: 1'b0};

    function automatic logic is_bean_flavor(input logic [2:0] flavor);
        return (flavor >= APPLE) && (flavor <= CHOCOLATE);
    endfunction

endpackage

// File: rtl/jelly_bean_dispenser_if.sv
// Bean bus between the dispenser (master) and the taster (slave).
interface jelly_bean_if;

    logic [2:0] jb_flavor;
    logic [1:0] jb_color;
    logic       jb_sugar_free;
    logic       jb_sour;
    logic [1:0] jb_taste;

    modport master_mp (
        output jb_flavor,
        output jb_color,
        output jb_sugar_free,
        output jb_sour,
        input  jb_taste
    );

    modport slave_mp (
        input  jb_flavor,
        input  jb_color,
        input  jb_sugar_free,
        input  jb_sour,
        output jb_taste
    );

endinterface

// File: rtl/jelly_bean_dispenser_fifo.sv
// Circular-buffer order FIFO with combinational head read.
module jelly_bean_order_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign o_rdata = r_mem[r_rd_ptr];

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array; contents need no reset.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wdata;
    end

endmodule

// File: rtl/jelly_bean_dispenser.sv
// Buffers bean orders, presents each to the taster, and reports the verdict.
module jelly_bean_dispenser
    import jb_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_ord_valid,
    output logic             o_ord_ready,
    input  logic [2:0]       i_ord_flavor,
    input  logic [1:0]       i_ord_color,
    input  logic             i_ord_sugar_free,
    input  logic             i_ord_sour,
    jelly_bean_if.master_mp  jb,
    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic [2:0]       o_rsp_flavor,
    output logic [1:0]       o_rsp_taste,
    output logic [CNT_W-1:0] o_yummy_count,
    output logic [CNT_W-1:0] o_yucky_count
);

    disp_state_e      r_state, w_state_d;
    order_t           r_bean, w_bean_d;
    logic             r_rsp_valid, w_rsp_valid_d;
    logic [2:0]       r_rsp_flavor, w_rsp_flavor_d;
    logic [1:0]       r_rsp_taste, w_rsp_taste_d;
    logic [CNT_W-1:0] r_yummy, w_yummy_d;
    logic [CNT_W-1:0] r_yucky, w_yucky_d;

    order_t w_ord_in;
    order_t w_head;
    logic   w_push;
    logic   w_pop;
    logic   w_full;
    logic   w_empty;

    assign w_ord_in = '{flavor: i_ord_flavor, color: i_ord_color,
                        sugar_free: i_ord_sugar_free, sour: i_ord_sour};
    assign o_ord_ready = !w_full && !rst;
    assign w_push = i_ord_valid && o_ord_ready;

    jelly_bean_order_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ORDER_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata (w_ord_in),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Next-state and datapath updates for the dispense/report sequence.
    always_comb begin
        w_state_d      = r_state;
        w_bean_d       = r_bean;
        w_rsp_valid_d  = r_rsp_valid;
        w_rsp_flavor_d = r_rsp_flavor;
        w_rsp_taste_d  = r_rsp_taste;
        w_yummy_d      = r_yummy;
        w_yucky_d      = r_yucky;
        w_pop          = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (!w_empty) begin
                    w_pop = 1'b1;
                    if (is_bean_flavor(w_head.flavor)) begin
                        w_bean_d  = w_head;
                        w_state_d = StDrive;
                    end else begin
                        // Invalid flavors skip the taster; response shows a cycle later.
                        w_rsp_flavor_d = w_head.flavor;
                        w_rsp_taste_d  = UNKNOWN;
                        w_state_d      = StReport;
                    end
                end
            end
            StDrive: begin
                w_state_d = StWait;
            end
            StWait: begin
                w_rsp_taste_d  = jb.jb_taste;
                w_rsp_flavor_d = r_bean.flavor;
                w_rsp_valid_d  = 1'b1;
                w_bean_d       = BEAN_IDLE;
                w_state_d      = StReport;
            end
            StReport: begin
                if (!r_rsp_valid) begin
                    w_rsp_valid_d = 1'b1;
                end else if (i_rsp_ready) begin
                    w_rsp_valid_d = 1'b0;
                    if (r_rsp_taste == YUMMY && r_yummy != '1) w_yummy_d = r_yummy + 1'b1;
                    if (r_rsp_taste == YUCKY && r_yucky != '1) w_yucky_d = r_yucky + 1'b1;
                    w_state_d = StIdle;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // State and output registers; reset idles the bus and drops any response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= StIdle;
            r_bean       <= BEAN_IDLE;
            r_rsp_valid  <= 1'b0;
            r_rsp_flavor <= '0;
            r_rsp_taste  <= UNKNOWN;
            r_yummy      <= '0;
            r_yucky      <= '0;
        end else begin
            r_state      <= w_state_d;
            r_bean       <= w_bean_d;
            r_rsp_valid  <= w_rsp_valid_d;
            r_rsp_flavor <= w_rsp_flavor_d;
            r_rsp_taste  <= w_rsp_taste_d;
            r_yummy      <= w_yummy_d;
            r_yucky      <= w_yucky_d;
        end
    end

    assign jb.jb_flavor     = r_bean.flavor;
    assign jb.jb_color      = r_bean.color;
    assign jb.jb_sugar_free = r_bean.sugar_free;
    assign jb.jb_sour       = r_bean.sour;
    assign o_rsp_valid      = r_rsp_valid;
    assign o_rsp_flavor     = r_rsp_flavor;
    assign o_rsp_taste      = r_rsp_taste;
    assign o_yummy_count    = r_yummy;
    assign o_yucky_count    = r_yucky;

endmodule

// File: doc/jelly_bean_dispenser.md
# jelly_bean_dispenser

Upstream stage of the jelly bean taster. Accepts bean orders over a valid/ready handshake and buffers them in a small FIFO. Presents each order, one at a time, on the taster's master-side bean bus, captures the taster's registered verdict, and returns an order/taste response over a second valid/ready handshake. Keeps saturating YUMMY/YUCKY tallies for the test harness.

## Interface
- DEPTH, 4, order FIFO entries (power of two, ≥2)
- CNT_W, 16, width of each taste tally
- clk  in  1  single clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- ord_valid  in  1  order present
- ord_ready  out  1  FIFO can accept; = !full, forced 0 while rst high
- ord_flavor  in  3  flavor_e
- ord_color  in  2  color_e
- ord_sugar_free  in  1  order attribute
- ord_sour  in  1  order attribute
- jb_flavor  out  3  bean bus to taster (registered)
- jb_color  out  2  bean bus (registered)
- jb_sugar_free  out  1  bean bus (registered)
- jb_sour  out  1  bean bus (registered)
- jb_taste  in  2  taste_e from taster, registered by the taster
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts
- rsp_flavor  out  3  flavor of the answered order
- rsp_taste  out  2  taste_e verdict
- yummy_count  out  CNT_W  completed YUMMY responses
- yucky_count  out  CNT_W  completed YUCKY responses

## Operation
- Order accepted on a clock edge with ord_valid && ord_ready. The FIFO stores {flavor, color, sugar_free, sour}.
- FSM states: IDLE, DRIVE, WAIT, REPORT.
- IDLE:
  - Bean bus = {NO_FLAVOR, RED, 0, 0}.
  - If the FIFO is not empty, pop the head.
  - Head flavor in APPLE..CHOCOLATE: load the head onto the bean bus and go to DRIVE.
  - Otherwise (NO_FLAVOR or 5..7): bus stays idle; load rsp_flavor = head flavor and rsp_taste = UNKNOWN; go to REPORT.
- DRIVE: hold the bean for one cycle; the taster samples it at the closing edge; go to WAIT.
- WAIT:
  - Hold the bean; jb_taste now reflects it.
  - At the closing edge, capture rsp_taste = jb_taste and rsp_flavor = bean flavor.
  - Return the bus to idle values and go to REPORT.
- REPORT: rsp_valid = 1 and rsp_* held stable until rsp_ready. On the handshake edge:
  - yummy_count increments if rsp_taste == YUMMY.
  - yucky_count increments if rsp_taste == YUCKY.
  - UNKNOWN increments neither.
  - Go to IDLE.
- Counters saturate at all-ones.
- A jb_taste value of 3 is captured as-is and counted in neither tally.

## Timing
- Reset values:
  - ord_ready 0 while rst is high.
  - Bean bus {0, 0, 0, 0}.
  - rsp_valid 0, rsp_flavor 0, rsp_taste UNKNOWN (0).
  - Both counters 0.
  - FIFO empty, state IDLE.
- Latency, with an empty FIFO and IDLE state:
  - Order accepted at edge T → pop/bus drive at T+1.
  - Taster samples at T+2; capture at T+3.
  - rsp_valid high from T+3.
  - Invalid-flavor order: rsp_valid high from T+2.
- Throughput: at most one bean per 4 cycles with rsp_ready held high; bus returns to idle for at least one cycle between beans.
- FIFO full: ord_ready = 0. Push and pop on the same edge when not full are both honoured, with count unchanged. ord_ready does not look ahead at a same-cycle pop.
- rsp_ready is ignored outside REPORT. Backpressure in REPORT stalls the FSM; the FIFO still accepts until full.
- Reset asserted mid-operation clears everything immediately: the in-flight bean and response are discarded and the bus goes idle asynchronously.

## Structure
- Shared package jb_pkg holds:
  - flavor_e {NO_FLAVOR, APPLE, BLUEBERRY, BUBBLE_GUM, CHOCOLATE} (3-bit)
  - color_e {RED, GREEN, BLUE} (2-bit)
  - taste_e {UNKNOWN, YUMMY, YUCKY} (2-bit)
- The dispenser and the taster both import jb_pkg.
- Sub-module jelly_bean_order_fifo:
  - Parameterised DEPTH and 7-bit width.
  - Circular buffer with pointer wrap and full/empty flags.
  - Asynchronous active-high reset.
- At top level, the bean bus and jb_taste connect through jelly_bean_if master_mp.

## Test plan
- Single order {CHOCOLATE, BLUE, 0, sour=1} with the real taster → rsp_valid at T+3, rsp_taste = YUCKY, yucky_count = 1.
- Orders APPLE, BLUEBERRY, BUBBLE_GUM back-to-back with rsp_ready high → three YUMMY responses in order, 4 cycles apart, yummy_count = 3; bus shows NO_FLAVOR between beans.
- Fill the FIFO with rsp_ready low → ord_ready drops after the FIFO holds DEPTH entries (plus the one order already popped to the bus); release rsp_ready → all orders are answered in FIFO order with none lost.
- Order with flavor 6 → no bus activity; response {6, UNKNOWN} at T+2; counters unchanged.
- Assert rst during WAIT → bus, rsp_valid and counters are 0 immediately; the next order after release behaves as in the first scenario.
- Force counters near saturation (CNT_W = 2) with 5 YUMMY beans → yummy_count sticks at 3.
